// File: rtl/path_pop_checker.sv
// path_pop_checker: consumes the priority-queue response word, checks that
// popped keys come out in priority order, counts pops and empty responses,
// and flags a stalled queue. Ends in a sticky PASS or FAIL verdict.
module path_pop_checker #(
  parameter int N_POPS    = 16,
  parameter int KEY_W     = 64,
  parameter int MIN_FIRST = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic [KEY_W+1:0] bodyVar_i,
  output logic             done,
  output logic             pass,
  output logic [1:0]       err_code,
  output logic [15:0]      pop_count,
  output logic [15:0]      empty_count,
  output logic [KEY_W-1:0] bad_key,
  output logic [15:0]      bad_index
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   last_key_q, last_key_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [15:0]        pop_q, pop_d;
  logic [15:0]        empty_q, empty_d;
  logic [KEY_W-1:0]   bad_key_q, bad_key_d;
  logic [15:0]        bad_index_q, bad_index_d;
  logic [1:0]         err_q, err_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic               in_vld, in_emp;
  logic [KEY_W-1:0]   in_key;
  logic               viol;

  assign in_vld = bodyVar_i[KEY_W+1];
  assign in_emp = bodyVar_i[KEY_W];
  assign in_key = bodyVar_i[KEY_W-1:0];

  // Out-of-order test; equal keys are always legal in either direction.
  assign viol = (MIN_FIRST != 0) ? (in_key < last_key_q) : (in_key > last_key_q);

  // Next-state and datapath: everything frozen once a verdict is reached.
  always_comb begin
    state_d     = state_q;
    last_key_d  = last_key_q;
    idle_d      = idle_q;
    pop_d       = pop_q;
    empty_d     = empty_q;
    bad_key_d   = bad_key_q;
    bad_index_d = bad_index_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (in_vld) begin
          idle_d = '0;
          if (in_emp) begin
            if (empty_q != 16'hFFFF) empty_d = empty_q + 16'd1;
          end else if (state_q == S_IDLE) begin
            // First pop only seeds the reference key.
            last_key_d = in_key;
            pop_d      = 16'd1;
            state_d    = (N_POPS == 1) ? S_PASS : S_RUN;
          end else if (viol) begin
            // Compare wins even on the pop that would have completed the run.
            bad_key_d   = in_key;
            bad_index_d = pop_q;
            err_d       = 2'd1;
            state_d     = S_FAIL;
          end else begin
            last_key_d = in_key;
            pop_d      = pop_q + 16'd1;
            if (pop_q + 16'd1 == 16'(N_POPS)) state_d = S_PASS;
          end
        end else begin
          idle_d = idle_q + IW'(1);
          if (idle_q == IW'(TIMEOUT - 1)) begin
            err_d   = 2'd2;
            state_d = S_FAIL;
          end
        end
      end
      default: ;
    endcase
    done_d = (state_d == S_PASS) || (state_d == S_FAIL);
    pass_d = (state_d == S_PASS);
  end

  // State and result registers, cleared asynchronously by reset.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= S_IDLE;
      last_key_q  <= '0;
      idle_q      <= '0;
      pop_q       <= '0;
      empty_q     <= '0;
      bad_key_q   <= '0;
      bad_index_q <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_key_q  <= last_key_d;
      idle_q      <= idle_d;
      pop_q       <= pop_d;
      empty_q     <= empty_d;
      bad_key_q   <= bad_key_d;
      bad_index_q <= bad_index_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign err_code    = err_q;
  assign pop_count   = pop_q;
  assign empty_count = empty_q;
  assign bad_key     = bad_key_q;
  assign bad_index   = bad_index_q;

endmodule
